// File: rtl/pallete_ctl.sv
// rtl/pallete_ctl.sv - frame-synchronous pallete position controller
// Optional acceleration under `define PALLETE_ACCEL_EN.
module pallete_ctl #(
  parameter int START_POS = 384,
  parameter int STEP      = 4,
  parameter int MIN_POS   = 100,
  parameter int MAX_POS   = 668,
  parameter int STEP_MAX  = 12
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vblnk_in,
  input  logic        btn_up,
  input  logic        btn_down,
  output logic [10:0] pallete_position,
  output logic        moving,
  output logic        at_limit
);

  localparam int SW = $clog2(STEP_MAX + 1);
  localparam logic signed [11:0] MIN_S = 12'(MIN_POS);
  localparam logic signed [11:0] MAX_S = 12'(MAX_POS);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN} state_t;

  state_t               state, state_nxt;
  logic                 up_m, up_s, down_m, down_s;
  logic                 vblnk_d, tick;
  logic [SW-1:0]        step_nxt;
  logic signed [11:0]   pos_ext, step_ext, pos_up, pos_dn;
  logic [10:0]          pos_nxt;

  always_ff @(posedge pclk) begin
    if (rst) begin
      up_m    <= 1'b0;
      up_s    <= 1'b0;
      down_m  <= 1'b0;
      down_s  <= 1'b0;
      vblnk_d <= 1'b0;
    end else begin
      up_m    <= btn_up;
      up_s    <= up_m;
      down_m  <= btn_down;
      down_s  <= down_m;
      vblnk_d <= vblnk_in;
    end
  end

  assign tick = vblnk_in & ~vblnk_d;

  always_ff @(posedge pclk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (tick) begin
      if (up_s && !down_s)      state_nxt = MOVE_UP;
      else if (!up_s && down_s) state_nxt = MOVE_DOWN;
      else                      state_nxt = IDLE;
    end
  end

`ifdef PALLETE_ACCEL_EN
  logic [SW-1:0] step;
  logic [2:0]    hold_cnt, hold_cnt_nxt;

  // Step grows by one each time the 3-bit hold counter wraps on a sustained run.
  always_comb begin
    step_nxt     = step;
    hold_cnt_nxt = hold_cnt;
    if (tick) begin
      if (state_nxt != IDLE && state_nxt == state) begin
        hold_cnt_nxt = hold_cnt + 3'd1;
        if (hold_cnt == 3'd7 && step < SW'(STEP_MAX)) step_nxt = step + SW'(1);
      end else begin
        step_nxt     = SW'(STEP);
        hold_cnt_nxt = 3'd0;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      step     <= SW'(STEP);
      hold_cnt <= 3'd0;
    end else begin
      step     <= step_nxt;
      hold_cnt <= hold_cnt_nxt;
    end
  end
`else
  assign step_nxt = SW'(STEP);
`endif

  // Widened signed math so the clamp sees true values before truncation.
  assign pos_ext  = {1'b0, pallete_position};
  assign step_ext = {{(12-SW){1'b0}}, step_nxt};
  assign pos_up   = pos_ext - step_ext;
  assign pos_dn   = pos_ext + step_ext;

  always_comb begin
    pos_nxt = pallete_position;
    if (tick) begin
      case (state_nxt)
        MOVE_UP:   pos_nxt = (pos_up < MIN_S) ? 11'(MIN_POS) : pos_up[10:0];
        MOVE_DOWN: pos_nxt = (pos_dn > MAX_S) ? 11'(MAX_POS) : pos_dn[10:0];
        default:   pos_nxt = pallete_position;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      pallete_position <= 11'(START_POS);
      moving           <= 1'b0;
      at_limit         <= 1'b0;
    end else begin
      pallete_position <= pos_nxt;
      moving           <= (state_nxt != IDLE);
      at_limit         <= (pos_nxt == 11'(MIN_POS)) || (pos_nxt == 11'(MAX_POS));
    end
  end

endmodule

// File: tb/tb_pallete_ctl.sv
// tb/tb_pallete_ctl.sv - scoreboard testbench for pallete_ctl
module tb_pallete_ctl;

  localparam int START_POS = 384;
  localparam int STEP      = 4;
  localparam int MIN_POS   = 100;
  localparam int MAX_POS   = 668;
  localparam int STEP_MAX  = 12;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        vblnk_in = 1'b0;
  logic        btn_up = 1'b0;
  logic        btn_down = 1'b0;
  logic [10:0] pallete_position;
  logic        moving;
  logic        at_limit;

  pallete_ctl dut (
    .pclk(pclk),
    .rst(rst),
    .vblnk_in(vblnk_in),
    .btn_up(btn_up),
    .btn_down(btn_down),
    .pallete_position(pallete_position),
    .moving(moving),
    .at_limit(at_limit)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int pos;
    int mv;
    int lim;
  } exp_t;

  exp_t exp_q[$];
  exp_t last;
  bit   have_last = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  int   m_pos = START_POS;
  int   m_dir = 0;
  int   m_run = 0;
  bit   ru, rd;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: one update per frame from the button levels at the tick.
  task automatic model_reset();
    m_pos = START_POS;
    m_dir = 0;
    m_run = 0;
    exp_q.push_back('{START_POS, 0, 0});
  endtask

  task automatic model_tick(input bit up, input bit dn);
    int dir;
    int st;
    dir = (up && !dn) ? 1 : ((!up && dn) ? 2 : 0);
    if (dir == 0)          m_run = 0;
    else if (dir == m_dir) m_run++;
    else                   m_run = 1;
    m_dir = dir;
    st = STEP;
`ifdef PALLETE_ACCEL_EN
    if (m_run > 0) st = STEP + (m_run - 1) / 8;
    if (st > STEP_MAX) st = STEP_MAX;
`endif
    if (dir == 1) m_pos = (m_pos - st < MIN_POS) ? MIN_POS : m_pos - st;
    if (dir == 2) m_pos = (m_pos + st > MAX_POS) ? MAX_POS : m_pos + st;
    exp_q.push_back('{m_pos, int'(dir != 0), int'(m_pos == MIN_POS || m_pos == MAX_POS)});
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic frame(input bit up, input bit dn, input int active, input int blank);
    btn_up   = up;
    btn_down = dn;
    vblnk_in = 1'b0;
    cyc(active);
    vblnk_in = 1'b1;
    model_tick(up, dn);
    cyc(blank);
    vblnk_in = 1'b0;
  endtask

  task automatic pulse_frame();
    btn_up   = 1'b0;
    btn_down = 1'b0;
    cyc(5);
    btn_down = 1'b1;
    cyc(500);
    btn_down = 1'b0;
    cyc(5);
    vblnk_in = 1'b1;
    model_tick(1'b0, 1'b0);
    cyc(3);
    vblnk_in = 1'b0;
  endtask

  task automatic reset_cycles(input int n, input bit vb);
    rst      = 1'b1;
    vblnk_in = vb;
    repeat (n) model_reset();
    cyc(n);
    rst      = 1'b0;
    vblnk_in = 1'b0;
  endtask

  // Observed events: a frame tick or a reset cycle each retire one expectation.
  logic vb_q = 1'b0;
  logic tick_ev = 1'b0;
  logic rst_ev = 1'b0;

  always @(posedge pclk) begin
    tick_ev <= vblnk_in & ~vb_q;
    rst_ev  <= rst;
    vb_q    <= rst ? 1'b0 : vblnk_in;
  end

  always @(negedge pclk) begin
    if (rst_ev || tick_ev) begin
      if (exp_q.size() == 0) begin
        chk("expectation_available", 0, 1);
      end else begin
        last = exp_q.pop_front();
        have_last = 1'b1;
        chk("pos", int'(pallete_position), last.pos);
        chk("moving", int'(moving), last.mv);
        chk("at_limit", int'(at_limit), last.lim);
      end
    end else if (have_last) begin
      chk("pos_stable", int'(pallete_position), last.pos);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    model_reset();
    model_reset();
    cyc(2);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) frame(1'b1, 1'b0, 6, 38);

    reset_cycles(1, 1'b0);
    for (int i = 0; i < 75; i++) frame(1'b1, 1'b0, 6, 3);
    for (int i = 0; i < 150; i++) frame(1'b0, 1'b1, 6, 3);

    for (int i = 0; i < 3; i++) frame(1'b1, 1'b1, 6, 3);
    pulse_frame();

    reset_cycles(1, 1'b0);
    for (int i = 0; i < 29; i++) frame(1'b0, 1'b1, 6, 3);
    cyc(2);
    reset_cycles(1, 1'b0);

    frame(1'b0, 1'b1, 6, 3);
    btn_down = 1'b1;
    cyc(4);
    reset_cycles(1, 1'b1);

    for (int i = 0; i < 20; i++) frame(1'b0, 1'b1, 6, 3);
    frame(1'b0, 1'b0, 6, 3);
    for (int i = 0; i < 3; i++) frame(1'b0, 1'b1, 6, 3);

    ru = 1'b0;
    rd = 1'b1;
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(5) == 0) begin
        ru = 1'($urandom_range(1));
        rd = 1'($urandom_range(1));
      end
      frame(ru, rd, $urandom_range(20, 4), $urandom_range(40, 1));
      if ($urandom_range(60) == 0) reset_cycles(1, 1'($urandom_range(1)));
    end

    cyc(5);
    chk("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
